// File: rtl/vga_sync_receiver.sv
// rtl/vga_sync_receiver.sv - VGA sync sink: recovers pixel position, checks line/frame timing, reports lock
module vga_sync_receiver #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  output logic       locked,
  output logic       display_en,
  output logic [9:0] col,
  output logic [9:0] row,
  output logic       timing_err,
  output logic [9:0] line_len
);

  localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
  localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
  localparam logic [9:0]  H_SYNC_W  = 10'(H_SYNC);
  localparam logic [9:0]  V_SYNC_W  = 10'(V_SYNC);
  localparam logic [9:0]  H_ACT_LO  = 10'(H_SYNC + H_BP);
  localparam logic [10:0] H_ACT_HI  = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0]  V_ACT_LO  = 10'(V_SYNC + V_BP);
  localparam logic [10:0] V_ACT_HI  = 11'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [3:0]  LOCK_W    = 4'(LOCK_FRAMES);
  localparam logic [9:0]  CNT_MAX   = 10'h3FF;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  good_q, good_d;

  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic [9:0]  hcnt_q, hcnt_d;
  logic [9:0]  hlow_q, hlow_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic [9:0]  vlow_q, vlow_d;
  logic        hwidth_ok_q, hwidth_ok_d;
  logic        bad_since_q, bad_since_d;

  logic        locked_q, locked_d;
  logic        display_en_q, display_en_d;
  logic [9:0]  col_q, col_d;
  logic [9:0]  row_q, row_d;
  logic        timing_err_q, timing_err_d;
  logic [9:0]  line_len_q, line_len_d;

  logic        hfall, vfall, hrise;
  logic [10:0] hcnt_inc, vcnt_inc;
  logic [9:0]  hcnt_sat, vcnt_sat, hlow_sat, vlow_sat;
  logic [3:0]  good_next;
  logic        line_bad, frame_ok, sync_lost;
  logic        h_in, v_in;

  // Edges compare the current sample against the registered previous one;
  // hs_q/vs_q reset low so a high must be seen before any fall counts.
  assign hfall = hs_q & ~hsync;
  assign vfall = vs_q & ~vsync;
  assign hrise = ~hs_q & hsync;

  assign hcnt_inc  = {1'b0, hcnt_q} + 11'd1;
  assign vcnt_inc  = {1'b0, vcnt_q} + 11'd1;
  assign hcnt_sat  = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + 10'd1;
  assign vcnt_sat  = (vcnt_q == CNT_MAX) ? vcnt_q : vcnt_q + 10'd1;
  assign hlow_sat  = (hlow_q == CNT_MAX) ? hlow_q : hlow_q + 10'd1;
  assign vlow_sat  = (vlow_q == CNT_MAX) ? vlow_q : vlow_q + 10'd1;
  assign good_next = {1'b0, good_q} + 4'd1;

  // A line is judged when the next one starts; a frame when the next vsync falls.
  // The frame verdict folds in the line that closes on the same sample.
  assign line_bad  = hfall & ~((hcnt_inc == H_TOTAL_W) & hwidth_ok_q);
  assign frame_ok  = (vcnt_inc == V_TOTAL_W) & (vlow_q == V_SYNC_W) & ~bad_since_q & ~line_bad;
  assign sync_lost = (hcnt_d == CNT_MAX);

  // Position counters, sync-width measurement and line-length capture
  always_comb begin
    hs_d        = hsync;
    vs_d        = vsync;
    hcnt_d      = hfall ? 10'd0 : hcnt_sat;
    hlow_d      = hsync ? 10'd0 : hlow_sat;
    hwidth_ok_d = hrise ? (hlow_q == H_SYNC_W) : hwidth_ok_q;
    vcnt_d      = vcnt_q;
    if (hfall) begin
      vcnt_d = vfall ? 10'd0 : vcnt_sat;
    end
    vlow_d = vlow_q;
    if (vfall) begin
      vlow_d = 10'd1;
    end else if (hfall && !vsync) begin
      vlow_d = vlow_sat;
    end
    bad_since_d = vfall ? 1'b0 : (bad_since_q | line_bad);
    line_len_d  = hfall ? hcnt_sat : line_len_q;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      hcnt_q      <= '0;
      hlow_q      <= '0;
      vcnt_q      <= '0;
      vlow_q      <= '0;
      hwidth_ok_q <= 1'b0;
      bad_since_q <= 1'b0;
      line_len_q  <= '0;
    end else begin
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      hcnt_q      <= hcnt_d;
      hlow_q      <= hlow_d;
      vcnt_q      <= vcnt_d;
      vlow_q      <= vlow_d;
      hwidth_ok_q <= hwidth_ok_d;
      bad_since_q <= bad_since_d;
      line_len_q  <= line_len_d;
    end
  end

  // Lock state and good-frame count registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= SEARCH;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
    end
  end

  // Lock FSM next state: search for a frame start, count good frames, drop on any violation
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      SEARCH: begin
        if (vfall) begin
          state_d = VERIFY;
          good_d  = '0;
        end
      end
      VERIFY: begin
        if (vfall) begin
          if (frame_ok) begin
            good_d = good_next[2:0];
            if (good_next == LOCK_W) begin
              state_d = LOCKED;
            end
          end else begin
            good_d = '0;
          end
        end else if (line_bad) begin
          good_d = '0;
        end
      end
      LOCKED: begin
        if (line_bad || (vfall && !frame_ok) || sync_lost) begin
          state_d = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // Output decode from the post-sample state and position; registered below for one clock latency
  always_comb begin
    timing_err_d = 1'b0;
    case (state_q)
      VERIFY:  timing_err_d = vfall ? !frame_ok : line_bad;
      LOCKED:  timing_err_d = line_bad || (vfall && !frame_ok) || sync_lost;
      default: timing_err_d = 1'b0;
    endcase
    locked_d     = (state_d == LOCKED);
    h_in         = (hcnt_d >= H_ACT_LO) && ({1'b0, hcnt_d} < H_ACT_HI);
    v_in         = (vcnt_d >= V_ACT_LO) && ({1'b0, vcnt_d} < V_ACT_HI);
    display_en_d = locked_d && h_in && v_in;
    col_d        = display_en_d ? (hcnt_d - H_ACT_LO) : 10'd0;
    row_d        = display_en_d ? (vcnt_d - V_ACT_LO) : 10'd0;
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      locked_q     <= 1'b0;
      display_en_q <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      timing_err_q <= 1'b0;
    end else begin
      locked_q     <= locked_d;
      display_en_q <= display_en_d;
      col_q        <= col_d;
      row_q        <= row_d;
      timing_err_q <= timing_err_d;
    end
  end

  assign locked     = locked_q;
  assign display_en = display_en_q;
  assign col        = col_q;
  assign row        = row_q;
  assign timing_err = timing_err_q;
  assign line_len   = line_len_q;

endmodule
